// File: rtl/sram_pkg.sv
// Shared defaults, limits and FSM state encoding for the SRAM behavioural model.
package sram_pkg;

  localparam int unsigned ADDR_W_DEF   = 18;
  localparam int unsigned DATA_W_DEF   = 16;
  localparam int unsigned READ_LAT_MAX = 7;
  localparam int unsigned LAT_W        = 3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    RD_DATA = 2'd2
  } state_t;

endpackage

// File: rtl/sram_model_counter.sv
// Loadable down-counter used for the read latency countdown; holds at zero.
module sram_model_counter #(
  parameter int unsigned W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst)
      count <= '0;
    else if (load)
      count <= load_val;
    else if (dec && count != '0)
      count <= count - W'(1);
  end

endmodule

// File: rtl/sram_model.sv
// Clocked model of an async 16-bit SRAM with byte lanes, programmable read
// latency, access counters and a sticky WE/OE conflict flag.
module sram_model
  import sram_pkg::*;
#(
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter int unsigned READ_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  inout  wire  [DATA_W-1:0] SRAM_DQ,
  input  logic [ADDR_W-1:0] SRAM_ADDR,
  input  logic              SRAM_UB_N,
  input  logic              SRAM_LB_N,
  input  logic              SRAM_WE_N,
  input  logic              SRAM_CE_N,
  input  logic              SRAM_OE_N,
  output logic [15:0]       rd_count,
  output logic [15:0]       wr_count,
  output logic              conflict
);

  localparam int unsigned     LANE_W   = DATA_W / 2;
  localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(READ_LAT - 1);

  logic [DATA_W-1:0] mem [0:(1 << ADDR_W) - 1] = '{default: '0};

  state_t            state, next_state;
  logic [ADDR_W-1:0] rd_addr, data_addr;
  logic [DATA_W-1:0] dout;
  logic [LAT_W-1:0]  lat_cnt;
  logic              wr_hit, rd_drive, start_read;
  logic              cnt_load, cnt_dec, addr_load, data_load, rd_inc;

  assign wr_hit   = !SRAM_CE_N && !SRAM_WE_N;
  assign rd_drive = (state == RD_DATA) && !SRAM_CE_N && !SRAM_OE_N && SRAM_WE_N;

  assign SRAM_DQ[DATA_W-1:LANE_W] = (rd_drive && !SRAM_UB_N) ? dout[DATA_W-1:LANE_W] : 'z;
  assign SRAM_DQ[LANE_W-1:0]      = (rd_drive && !SRAM_LB_N) ? dout[LANE_W-1:0]      : 'z;

  sram_model_counter #(.W(LAT_W)) u_lat (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .dec      (cnt_dec),
    .load_val (LAT_LOAD),
    .count    (lat_cnt)
  );

  always_comb begin
    next_state = state;
    start_read = 1'b0;
    cnt_load   = 1'b0;
    cnt_dec    = 1'b0;
    addr_load  = 1'b0;
    data_load  = 1'b0;
    rd_inc     = 1'b0;
    if (wr_hit) begin
      next_state = IDLE;
    end else begin
      case (state)
        IDLE: start_read = !SRAM_CE_N && !SRAM_OE_N;
        RD_WAIT, RD_DATA: begin
          if (SRAM_CE_N || SRAM_OE_N)
            next_state = IDLE;
          else if (SRAM_ADDR != rd_addr)
            start_read = 1'b1;
          else if (state == RD_WAIT) begin
            if (lat_cnt == '0) begin
              data_load  = 1'b1;
              rd_inc     = 1'b1;
              next_state = RD_DATA;
            end else begin
              cnt_dec = 1'b1;
            end
          end
        end
        default: next_state = IDLE;
      endcase
    end
    // Accept and address-change restart share one path, so READ_LAT=1
    // fetches straight from the pins and lands in RD_DATA one edge later.
    if (start_read) begin
      addr_load = 1'b1;
      if (READ_LAT == 1) begin
        data_load  = 1'b1;
        rd_inc     = 1'b1;
        next_state = RD_DATA;
      end else begin
        cnt_load   = 1'b1;
        next_state = RD_WAIT;
      end
    end
  end

  assign data_addr = start_read ? SRAM_ADDR : rd_addr;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      rd_addr  <= '0;
      dout     <= '0;
      rd_count <= '0;
      wr_count <= '0;
      conflict <= 1'b0;
    end else begin
      state <= next_state;
      if (addr_load) rd_addr  <= SRAM_ADDR;
      if (data_load) dout     <= mem[data_addr];
      if (rd_inc)    rd_count <= rd_count + 16'd1;
      if (wr_hit)    wr_count <= wr_count + 16'd1;
      if (wr_hit && !SRAM_OE_N) conflict <= 1'b1;
    end
  end

  // Storage is deliberately outside the reset domain; reset only blocks writes.
  always_ff @(posedge clk) begin
    if (!rst && wr_hit) begin
      if (!SRAM_UB_N) mem[SRAM_ADDR][DATA_W-1:LANE_W] <= SRAM_DQ[DATA_W-1:LANE_W];
      if (!SRAM_LB_N) mem[SRAM_ADDR][LANE_W-1:0]      <= SRAM_DQ[LANE_W-1:0];
    end
  end

endmodule

// File: tb/tb_sram_model.sv
// Directed bench for sram_model: vector table plus reset, latency-1 and counter wrap sequences.
module tb_sram_model;

  logic        clk = 1'b0;
  logic        rst;
  logic [17:0] addr;
  logic        ub_n, lb_n, we_n, ce_n, oe_n;
  logic [15:0] drv;
  logic        drv_en;
  wire  [15:0] dq, dq1;
  logic [15:0] rd_count, wr_count, rd1, wr1;
  logic        conflict, conf1;

  int unsigned errors = 0;
  int unsigned checks = 0;

  always #5 clk = ~clk;

  assign dq  = drv_en ? drv : 'z;
  assign dq1 = drv_en ? drv : 'z;

  for (genvar i = 0; i < 16; i++) begin : g_pu
    pullup (dq[i]);
    pullup (dq1[i]);
  end

  sram_model #(.ADDR_W(18), .DATA_W(16), .READ_LAT(2)) dut (
    .clk(clk), .rst(rst), .SRAM_DQ(dq), .SRAM_ADDR(addr),
    .SRAM_UB_N(ub_n), .SRAM_LB_N(lb_n), .SRAM_WE_N(we_n),
    .SRAM_CE_N(ce_n), .SRAM_OE_N(oe_n),
    .rd_count(rd_count), .wr_count(wr_count), .conflict(conflict)
  );

  sram_model #(.ADDR_W(18), .DATA_W(16), .READ_LAT(1)) dut1 (
    .clk(clk), .rst(rst), .SRAM_DQ(dq1), .SRAM_ADDR(addr),
    .SRAM_UB_N(ub_n), .SRAM_LB_N(lb_n), .SRAM_WE_N(we_n),
    .SRAM_CE_N(ce_n), .SRAM_OE_N(oe_n),
    .rd_count(rd1), .wr_count(wr1), .conflict(conf1)
  );

  typedef struct {
    logic        ce_n, we_n, oe_n, ub_n, lb_n;
    logic [17:0] addr;
    logic [15:0] din;
    logic [15:0] exp_dq, exp_rd, exp_wr;
    logic        exp_conf;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t v(logic c, logic w, logic o, logic u, logic l,
                             logic [17:0] a, logic [15:0] d, logic [15:0] edq,
                             logic [15:0] erd, logic [15:0] ewr, logic ecf);
    vec_t r;
    r.ce_n = c; r.we_n = w; r.oe_n = o; r.ub_n = u; r.lb_n = l;
    r.addr = a; r.din = d; r.exp_dq = edq; r.exp_rd = erd; r.exp_wr = ewr;
    r.exp_conf = ecf;
    return r;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic pins(logic c, logic w, logic o, logic u, logic l,
                      logic [17:0] a, logic [15:0] d);
    ce_n = c; we_n = w; oe_n = o; ub_n = u; lb_n = l; addr = a; drv = d;
    drv_en = !c && !w;
  endtask

  initial begin
    rst = 1'b1;
    pins(1, 1, 1, 0, 0, '0, '0);

    // idle -> read 0x5 (never written) -> 0x0000
    vecs.push_back(v(0,1,0,0,0, 18'h5,  16'h0,    16'hFFFF, 0, 0, 0));
    vecs.push_back(v(0,1,0,0,0, 18'h5,  16'h0,    16'hFFFF, 0, 0, 0));
    vecs.push_back(v(0,1,0,0,0, 18'h5,  16'h0,    16'h0000, 1, 0, 0));
    vecs.push_back(v(1,1,1,0,0, 18'h5,  16'h0,    16'hFFFF, 1, 0, 0));
    // write BEEF @10, read back at latency 2, lane masking, deselect
    vecs.push_back(v(0,0,1,0,0, 18'h10, 16'hBEEF, 16'hBEEF, 1, 1, 0));
    vecs.push_back(v(0,1,0,0,0, 18'h10, 16'h0,    16'hFFFF, 1, 1, 0));
    vecs.push_back(v(0,1,0,0,0, 18'h10, 16'h0,    16'hFFFF, 1, 1, 0));
    vecs.push_back(v(0,1,0,0,0, 18'h10, 16'h0,    16'hBEEF, 2, 1, 0));
    vecs.push_back(v(0,1,0,0,0, 18'h10, 16'h0,    16'hBEEF, 2, 1, 0));
    vecs.push_back(v(0,1,0,1,0, 18'h10, 16'h0,    16'hFFEF, 2, 1, 0));
    vecs.push_back(v(1,1,1,0,0, 18'h10, 16'h0,    16'hFFFF, 2, 1, 0));
    // byte-lane write merge at 0x20
    vecs.push_back(v(0,0,1,0,0, 18'h20, 16'h1234, 16'h1234, 2, 2, 0));
    vecs.push_back(v(0,0,1,0,1, 18'h20, 16'hAB00, 16'hAB00, 2, 3, 0));
    vecs.push_back(v(0,1,0,0,0, 18'h20, 16'h0,    16'hFFFF, 2, 3, 0));
    vecs.push_back(v(0,1,0,0,0, 18'h20, 16'h0,    16'hFFFF, 2, 3, 0));
    vecs.push_back(v(0,1,0,0,0, 18'h20, 16'h0,    16'hAB34, 3, 3, 0));
    vecs.push_back(v(1,1,1,0,0, 18'h20, 16'h0,    16'hFFFF, 3, 3, 0));
    // address change in RD_WAIT, then in RD_DATA
    vecs.push_back(v(0,1,0,0,0, 18'h10, 16'h0,    16'hFFFF, 3, 3, 0));
    vecs.push_back(v(0,1,0,0,0, 18'h20, 16'h0,    16'hFFFF, 3, 3, 0));
    vecs.push_back(v(0,1,0,0,0, 18'h20, 16'h0,    16'hFFFF, 3, 3, 0));
    vecs.push_back(v(0,1,0,0,0, 18'h20, 16'h0,    16'hAB34, 4, 3, 0));
    vecs.push_back(v(0,1,0,0,0, 18'h10, 16'h0,    16'hFFFF, 4, 3, 0));
    vecs.push_back(v(0,1,0,0,0, 18'h10, 16'h0,    16'hFFFF, 4, 3, 0));
    vecs.push_back(v(0,1,0,0,0, 18'h10, 16'h0,    16'hBEEF, 5, 3, 0));
    // WE/OE conflict from RD_DATA: bench alone drives DQ, flag sticks
    vecs.push_back(v(0,0,0,0,0, 18'h30, 16'h5555, 16'h5555, 5, 4, 1));
    vecs.push_back(v(1,1,1,0,0, 18'h30, 16'h0,    16'hFFFF, 5, 4, 1));
    vecs.push_back(v(0,1,0,0,0, 18'h30, 16'h0,    16'hFFFF, 5, 4, 1));
    vecs.push_back(v(0,1,0,0,0, 18'h30, 16'h0,    16'hFFFF, 5, 4, 1));
    vecs.push_back(v(0,1,0,0,0, 18'h30, 16'h0,    16'h5555, 6, 4, 1));

    // reset state
    tick();
    tick();
    chk("rst dq", dq, 16'hFFFF);
    chk("rst rd_count", rd_count, 16'h0);
    chk("rst wr_count", wr_count, 16'h0);
    chk("rst conflict", conflict, 1'b0);
    rst = 1'b0;

    foreach (vecs[i]) begin
      pins(vecs[i].ce_n, vecs[i].we_n, vecs[i].oe_n, vecs[i].ub_n, vecs[i].lb_n,
           vecs[i].addr, vecs[i].din);
      tick();
      chk($sformatf("v%0d dq", i), dq, vecs[i].exp_dq);
      chk($sformatf("v%0d rd_count", i), rd_count, vecs[i].exp_rd);
      chk($sformatf("v%0d wr_count", i), wr_count, vecs[i].exp_wr);
      chk($sformatf("v%0d conflict", i), conflict, vecs[i].exp_conf);
    end

    // reset pulse while in RD_DATA; storage survives
    rst = 1'b1;
    tick();
    chk("rdrst dq", dq, 16'hFFFF);
    chk("rdrst rd_count", rd_count, 16'h0);
    chk("rdrst wr_count", wr_count, 16'h0);
    chk("rdrst conflict", conflict, 1'b0);
    rst = 1'b0;
    tick();
    chk("post-rst accept dq", dq, 16'hFFFF);
    chk("lat1 dq", dq1, 16'h5555);
    chk("lat1 rd_count", rd1, 16'h1);
    tick();
    chk("post-rst wait dq", dq, 16'hFFFF);
    tick();
    chk("post-rst data dq", dq, 16'h5555);
    chk("post-rst rd_count", rd_count, 16'h1);
    pins(0, 1, 0, 0, 0, 18'h10, '0);
    tick();
    chk("lat1 restart dq", dq1, 16'hBEEF);
    chk("lat1 restart rd_count", rd1, 16'h2);
    chk("restart dq", dq, 16'hFFFF);
    tick();
    tick();
    chk("restart data dq", dq, 16'hBEEF);
    chk("restart rd_count", rd_count, 16'h2);

    // reset outranks a simultaneous write
    rst = 1'b1;
    pins(0, 0, 1, 0, 0, 18'h10, 16'h0000);
    tick();
    rst = 1'b0;
    pins(1, 1, 1, 0, 0, 18'h10, '0);
    tick();
    chk("rstwr wr_count", wr_count, 16'h0);
    pins(0, 1, 0, 0, 0, 18'h10, '0);
    tick();
    tick();
    tick();
    chk("rstwr dropped dq", dq, 16'hBEEF);

    // write counter wrap
    pins(0, 0, 1, 0, 0, 18'h40, 16'h1357);
    repeat (65535) @(posedge clk);
    @(negedge clk);
    chk("wrap wr_count max", wr_count, 16'hFFFF);
    tick();
    chk("wrap wr_count zero", wr_count, 16'h0000);
    pins(1, 1, 1, 0, 0, '0, '0);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
